bounce_gen: RTL and testbench

BOUNCE_GEN -- requirements
Module: bounce_gen

---
 rtl/bounce_gen.sv | 171 +++++++++++++++++
 tb/tb_bounce_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_gen.sv
// Contact-bounce generator: on request, toggles o_line 2*GLITCH_N+1 times, then holds it for SETTLE_N cycles.
// Define BOUNCE_GEN_RANDOM_EN to draw segment widths from an 8-bit LFSR instead of using GLITCH_MAX.
module bounce_gen #(
    parameter int unsigned GLITCH_N   = 3,
    parameter int unsigned GLITCH_MAX = 5,
    parameter int unsigned SETTLE_N   = 8,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_level,
    output logic       o_line,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_state
);

    localparam int unsigned TOG_TOTAL = 2 * GLITCH_N + 1;
    localparam int TOG_W = $clog2(TOG_TOTAL + 1);
    localparam int SEG_W = $clog2(GLITCH_MAX + 1);
    localparam int SET_W = $clog2(SETTLE_N + 1);
    localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(TOG_TOTAL);
    localparam logic [SEG_W-1:0] SEG_MAX  = SEG_W'(GLITCH_MAX);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               line_q, line_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               target_q, target_d;
    logic [TOG_W-1:0]   tog_q, tog_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic [TOG_W-1:0]   tog_inc;
    logic [SEG_W-1:0]   w_cur;

`ifdef BOUNCE_GEN_RANDOM_EN
    localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    logic [7:0]       lfsr_q;
    logic [SEG_W-1:0] w_q, w_d;
    logic [8:0]       w_raw;
    logic [SEG_W-1:0] w_sample;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; free-running in every state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_q <= SEED_EFF;
            w_q    <= '0;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            w_q    <= w_d;
        end
    end

    assign w_raw    = ({1'b0, lfsr_q} % 9'(GLITCH_MAX)) + 9'd1;
    assign w_sample = SEG_W'(w_raw);
    assign w_cur    = w_q;
`else
    assign w_cur = SEG_MAX;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            line_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            target_q <= 1'b0;
            tog_q    <= '0;
            seg_q    <= '0;
            set_q    <= '0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            target_q <= target_d;
            tog_q    <= tog_d;
            seg_q    <= seg_d;
            set_q    <= set_d;
        end
    end

    assign tog_inc = tog_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        target_d = target_q;
        tog_d    = tog_q;
        seg_d    = seg_q;
        set_d    = set_q;
`ifdef BOUNCE_GEN_RANDOM_EN
        w_d      = w_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (i_start) begin
                    if (i_level != line_q) begin
                        target_d = i_level;
                        line_d   = ~line_q;
                        busy_d   = 1'b1;
                        tog_d    = TOG_W'(1);
                        seg_d    = SEG_W'(1);
`ifdef BOUNCE_GEN_RANDOM_EN
                        w_d      = w_sample;
`endif
                        // With no glitches the first toggle is already the final one.
                        if (TOG_LAST == TOG_W'(1)) begin
                            state_d = SETTLE;
                            set_d   = SET_W'(1);
                        end else begin
                            state_d = BOUNCE;
                        end
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            BOUNCE: begin
                if (seg_q >= w_cur) begin
                    line_d = ~line_q;
                    tog_d  = tog_inc;
                    seg_d  = SEG_W'(1);
`ifdef BOUNCE_GEN_RANDOM_EN
                    w_d    = w_sample;
`endif
                    if (tog_inc >= TOG_LAST) begin
                        line_d  = target_q;
                        state_d = SETTLE;
                        set_d   = SET_W'(1);
                    end
                end else begin
                    seg_d = seg_q + 1'b1;
                end
            end
            SETTLE: begin
                if (set_q >= SET_LAST) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    tog_d   = '0;
                    seg_d   = '0;
                    set_d   = '0;
                end else begin
                    set_d = set_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign o_line  = line_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: event-level reference (toggle count, segment widths, settle time, final level).
module tb_bounce_gen;

    localparam int G_N   = 3;
    localparam int G_MAX = 5;
    localparam int S_N   = 8;
    localparam int TOGS  = 2 * G_N + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, level = 1'b0;
    logic       line, busy, done;
    logic [1:0] state;
    logic       start2 = 1'b0, level2 = 1'b0;
    logic       line2, busy2, done2;
    logic [1:0] state2;

    int vectors = 0;
    int errs    = 0;
    int n_done  = 0;
    int n_req   = 0;

    always #5 clk = ~clk;

    bounce_gen #(.GLITCH_N(G_N), .GLITCH_MAX(G_MAX), .SETTLE_N(S_N), .LFSR_SEED(8'hA5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_level(level),
        .o_line(line), .o_busy(busy), .o_done(done), .o_state(state)
    );

    bounce_gen #(.GLITCH_N(0), .GLITCH_MAX(G_MAX), .SETTLE_N(4), .LFSR_SEED(8'h00)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_level(level2),
        .o_line(line2), .o_busy(busy2), .o_done(done2), .o_state(state2)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request; checks the whole waveform against the rules and returns with o_done visible.
    task automatic run_req(input logic lvl, input bit noise, output bit accepted);
        logic prev, last_line;
        int   cyc, t_last, toggles, w;
        bit   got;
        prev = line;
        n_req++;
        start = 1'b1;
        level = lvl;
        tick();
        start = 1'b0;
        if (lvl == prev) begin
            accepted = 1'b0;
            vectors++;
            if (done !== 1'b1 || busy !== 1'b0 || line !== prev) begin
                errs++;
                $display("FAIL noop: done=%b busy=%b line=%b, want done=1 busy=0 line=%b", done, busy, line, prev);
            end
            if (done === 1'b1) n_done++;
            return;
        end
        accepted = 1'b1;
        vectors++;
        if (line !== ~prev || busy !== 1'b1 || done !== 1'b0) begin
            errs++;
            $display("FAIL first_toggle: line=%b busy=%b done=%b, want line=%b busy=1 done=0", line, busy, done, ~prev);
        end
        toggles = 1;
        cyc = 0;
        t_last = 0;
        last_line = line;
        got = 1'b0;
        while (cyc < 2000 && !got) begin
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                level = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
            if (line !== last_line) begin
                toggles++;
                w = cyc - t_last;
                vectors++;
`ifdef BOUNCE_GEN_RANDOM_EN
                if (w < 1 || w > G_MAX) begin
`else
                if (w != G_MAX) begin
`endif
                    errs++;
                    $display("FAIL segment_width: got %0d cycles, max %0d (toggle %0d)", w, G_MAX, toggles);
                end
                t_last = cyc;
                last_line = line;
            end
            if (done === 1'b1) begin
                got = 1'b1;
                start = 1'b0;
                n_done++;
                vectors++;
                if (cyc - t_last != S_N || toggles != TOGS || line !== lvl || busy !== 1'b0) begin
                    errs++;
                    $display("FAIL completion: settle=%0d toggles=%0d line=%b busy=%b, want settle=%0d toggles=%0d line=%b busy=0",
                             cyc - t_last, toggles, line, busy, S_N, TOGS, lvl);
                end
            end else if (busy !== 1'b1) begin
                vectors++;
                errs++;
                $display("FAIL busy_drop: busy=%b at cycle %0d of request, want 1", busy, cyc);
            end
        end
        if (!got) begin
            vectors++;
            errs++;
            start = 1'b0;
            $display("FAIL timeout: no o_done within 2000 cycles");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        vectors++;
        if (line !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || state !== 2'd0 ||
            line2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            errs++;
            $display("FAIL reset: line=%b busy=%b done=%b state=%0d line2=%b busy2=%b done2=%b, want all 0",
                     line, busy, done, state, line2, busy2, done2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        bit acc;
        repeat (9) tick();
        run_req(1'b1, 1'b0, acc);
        vectors++;
        if (acc !== 1'b1) begin
            errs++;
            $display("FAIL fixed_accept: accepted=%b want 1", acc);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || line !== 1'b1) begin
            errs++;
            $display("FAIL done_pulse: done=%b busy=%b line=%b, want 0 0 1", done, busy, line);
        end
    endtask

    task automatic test_noop();
        bit acc;
        int tog = 0;
        run_req(1'b1, 1'b0, acc);
        vectors++;
        if (acc !== 1'b0) begin
            errs++;
            $display("FAIL noop_accept: accepted=%b want 0", acc);
        end
        repeat (10) begin
            tick();
            if (line !== 1'b1 || busy !== 1'b0 || done !== 1'b0) tog++;
        end
        vectors++;
        if (tog != 0) begin
            errs++;
            $display("FAIL noop_quiet: %0d cycles with activity, want 0", tog);
        end
    endtask

    task automatic test_noise();
        bit acc;
        run_req(1'b0, 1'b1, acc);
        run_req(1'b1, 1'b1, acc);
    endtask

    task automatic test_abort(input int depth);
        int  extra = 0;
        bit  acc;
        logic tgt;
        tgt = ~line;
        start = 1'b1;
        level = tgt;
        tick();
        start = 1'b0;
        repeat (depth) tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (line !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL abort_%0d: line=%b busy=%b done=%b, want 0 0 0", depth, line, busy, done);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        if (depth < 20) begin
            repeat (5) begin
                tick();
                if (done !== 1'b0 || busy !== 1'b0) extra++;
            end
            vectors++;
            if (extra != 0) begin
                errs++;
                $display("FAIL abort_quiet: %0d cycles with done/busy after abort, want 0", extra);
            end
        end
        run_req(1'b1, 1'b0, acc);
        vectors++;
        if (acc !== 1'b1) begin
            errs++;
            $display("FAIL post_reset_accept: accepted=%b want 1", acc);
        end
    endtask

    task automatic test_glitch0();
        int cyc = 0;
        int bad = 0;
        logic tgt;
        tgt = ~line2;
        start2 = 1'b1;
        level2 = tgt;
        tick();
        start2 = 1'b0;
        vectors++;
        if (line2 !== tgt || busy2 !== 1'b1) begin
            errs++;
            $display("FAIL g0_toggle: line2=%b busy2=%b, want %b 1", line2, busy2, tgt);
        end
        while (cyc < 100 && done2 !== 1'b1) begin
            tick();
            cyc++;
            if (line2 !== tgt) bad++;
        end
        vectors++;
        if (cyc != 4 || bad != 0 || busy2 !== 1'b0) begin
            errs++;
            $display("FAIL g0_done: done after %0d cycles, %0d extra toggles, busy2=%b; want 4, 0, 0", cyc, bad, busy2);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int d0, r0;
        d0 = n_done;
        r0 = n_req;
        for (int i = 0; i < 200; i++) begin
            run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
        end
        vectors++;
        if (n_done - d0 != n_req - r0) begin
            errs++;
            $display("FAIL b2b_count: %0d done pulses for %0d requests", n_done - d0, n_req - r0);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_noop();
        test_noise();
        test_abort(9);
        test_abort(33);
        test_glitch0();
        test_glitch0();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
